// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB transaction sequencer and its helpers.
package usb_pkg;

    // Default data buffer capacity in bytes.
    localparam int unsigned BUF_DEPTH_DEFAULT = 64;

    // PIDs as decoded by the RX controller.
    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_OUT   = 3'd1,
        RX_IN    = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6,
        RX_SETUP = 3'd7
    } rx_pid_t;

    // Packets the TX encoder can be told to send.
    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_pid_t;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OUT_DATA = 3'd1,
        ST_OUT_SKIP = 3'd2,
        ST_SEND_ACK = 3'd3,
        ST_SEND_NAK = 3'd4,
        ST_IN_SEND  = 3'd5,
        ST_IN_WAIT  = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/xact_timer.sv
// Loadable saturating up-counter used to time out missing host responses.
// Counts to LIMIT and holds there; timeout_o is high while at LIMIT.
module xact_timer #(
    parameter  int unsigned LIMIT = 511,
    localparam int unsigned W     = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         timeout_o
);

    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] count_q;

    // Counter register: clear beats load beats increment; saturates at MAX.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign timeout_o = (count_q == MAX);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB transaction sequencer: decodes RX PIDs, commands the TX encoder,
// tracks DATA0/DATA1 toggles, arbitrates buffer ownership and times out
// transactions the host abandons. All outputs are registered.
module usb_protocol_ctrl
    import usb_pkg::*;
#(
    parameter  int unsigned TIMEOUT_CYCLES = 512,
    parameter  int unsigned BUF_DEPTH      = BUF_DEPTH_DEFAULT,
    localparam int unsigned OCC_W          = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  rx_pid_t          rx_packet,
    input  logic             rx_packet_valid,
    input  logic             rx_error,
    input  logic             tx_done,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic             ahb_tx_commit,
    output tx_pid_t          tx_packet,
    output logic             d_mode,
    output logic             buffer_clear,
    output logic             rx_data_avail,
    output logic             tx_complete,
    output logic             xact_error,
    output logic             busy
);

    ctrl_state_t state_q, state_d;

    logic    out_toggle_q, out_toggle_d;
    logic    in_toggle_q, in_toggle_d;
    logic    fresh_q, fresh_d;          // ACK in flight covers a new payload
    tx_pid_t tx_packet_q, tx_packet_d;
    logic    d_mode_q, d_mode_d;
    logic    buffer_clear_q, buffer_clear_d;
    logic    rx_data_avail_q, rx_data_avail_d;
    logic    tx_complete_q, tx_complete_d;
    logic    xact_error_q, xact_error_d;
    logic    busy_q, busy_d;

    logic timeout;
    logic pkt_ok;
    logic rx_is_data;
    logic rx_data_tgl;
    logic occ_empty;
    logic timer_en;

    assign pkt_ok      = rx_packet_valid && !rx_error;
    assign rx_is_data  = (rx_packet == RX_DATA0) || (rx_packet == RX_DATA1);
    assign rx_data_tgl = (rx_packet == RX_DATA1);
    assign occ_empty   = (buffer_occupancy == '0);
    assign timer_en    = (state_q == ST_OUT_DATA) || (state_q == ST_OUT_SKIP) ||
                         (state_q == ST_IN_WAIT);

    // The timer restarts on every state change, so each timed state starts at 0.
    xact_timer #(
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_i    (state_d != state_q),
        .en_i       (timer_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .timeout_o  (timeout)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a packet on the same cycle as a timeout takes priority.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pkt_ok) begin
                    if ((rx_packet == RX_OUT) || (rx_packet == RX_SETUP)) begin
                        state_d = occ_empty ? ST_OUT_DATA : ST_OUT_SKIP;
                    end else if (rx_packet == RX_IN) begin
                        state_d = (ahb_tx_commit && !occ_empty) ? ST_IN_SEND : ST_SEND_NAK;
                    end
                end
            end
            ST_OUT_DATA: begin
                if (rx_error) begin
                    state_d = ST_IDLE;
                end else if (rx_packet_valid) begin
                    state_d = rx_is_data ? ST_SEND_ACK : ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT_SKIP: begin
                if (pkt_ok && rx_is_data) begin
                    state_d = ST_SEND_NAK;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_ACK, ST_SEND_NAK: begin
                if (tx_done) state_d = ST_IDLE;
            end
            ST_IN_SEND: begin
                if (tx_done) state_d = ST_IN_WAIT;
            end
            ST_IN_WAIT: begin
                if (rx_error || rx_packet_valid || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and toggle decode from the current state, the transition and its cause.
    always_comb begin
        out_toggle_d    = out_toggle_q;
        in_toggle_d     = in_toggle_q;
        fresh_d         = fresh_q;
        d_mode_d        = d_mode_q;
        buffer_clear_d  = 1'b0;
        rx_data_avail_d = 1'b0;
        tx_complete_d   = 1'b0;
        xact_error_d    = 1'b0;
        busy_d          = (state_d != ST_IDLE);

        if ((state_d == ST_OUT_DATA) || (state_d == ST_IN_SEND)) begin
            d_mode_d = 1'b1;
        end else if (state_d == ST_IDLE) begin
            d_mode_d = 1'b0;
        end

        unique case (state_d)
            ST_SEND_ACK: tx_packet_d = TX_ACK;
            ST_SEND_NAK: tx_packet_d = TX_NAK;
            ST_IN_SEND:  tx_packet_d = in_toggle_q ? TX_DATA1 : TX_DATA0;
            default:     tx_packet_d = TX_NONE;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (pkt_ok && (rx_packet == RX_SETUP)) begin
                    out_toggle_d = 1'b0;
                    in_toggle_d  = 1'b0;
                end
            end
            ST_OUT_DATA: begin
                if (state_d == ST_SEND_ACK) begin
                    if (rx_data_tgl == out_toggle_q) begin
                        out_toggle_d = ~out_toggle_q;
                        fresh_d      = 1'b1;
                    end else begin
                        // Host missed our last ACK: drop the duplicate and re-ACK.
                        buffer_clear_d = 1'b1;
                        fresh_d        = 1'b0;
                    end
                end else if (state_d == ST_IDLE) begin
                    buffer_clear_d = 1'b1;
                    xact_error_d   = 1'b1;
                end
            end
            ST_SEND_ACK: begin
                if (tx_done) begin
                    rx_data_avail_d = fresh_q;
                    fresh_d         = 1'b0;
                end
            end
            ST_IN_WAIT: begin
                if (state_d == ST_IDLE) begin
                    if (pkt_ok && (rx_packet == RX_ACK)) begin
                        in_toggle_d    = ~in_toggle_q;
                        buffer_clear_d = 1'b1;
                        tx_complete_d  = 1'b1;
                    end else begin
                        // Keep the payload and toggle so the AHB data can be resent.
                        xact_error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output, toggle and bookkeeping registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_toggle_q    <= 1'b0;
            in_toggle_q     <= 1'b0;
            fresh_q         <= 1'b0;
            tx_packet_q     <= TX_NONE;
            d_mode_q        <= 1'b0;
            buffer_clear_q  <= 1'b0;
            rx_data_avail_q <= 1'b0;
            tx_complete_q   <= 1'b0;
            xact_error_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            out_toggle_q    <= out_toggle_d;
            in_toggle_q     <= in_toggle_d;
            fresh_q         <= fresh_d;
            tx_packet_q     <= tx_packet_d;
            d_mode_q        <= d_mode_d;
            buffer_clear_q  <= buffer_clear_d;
            rx_data_avail_q <= rx_data_avail_d;
            tx_complete_q   <= tx_complete_d;
            xact_error_q    <= xact_error_d;
            busy_q          <= busy_d;
        end
    end

    assign tx_packet     = tx_packet_q;
    assign d_mode        = d_mode_q;
    assign buffer_clear  = buffer_clear_q;
    assign rx_data_avail = rx_data_avail_q;
    assign tx_complete   = tx_complete_q;
    assign xact_error    = xact_error_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Directed self-checking bench for usb_protocol_ctrl.
module tb_usb_protocol_ctrl;
    import usb_pkg::*;

    localparam int unsigned TIMEOUT = 512;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    rx_pid_t    rx_packet = RX_NONE;
    logic       rx_packet_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       tx_done = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       ahb_tx_commit = 1'b0;
    tx_pid_t    tx_packet;
    logic       d_mode, buffer_clear, rx_data_avail, tx_complete, xact_error, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    usb_protocol_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .BUF_DEPTH      (64)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .rx_packet        (rx_packet),
        .rx_packet_valid  (rx_packet_valid),
        .rx_error         (rx_error),
        .tx_done          (tx_done),
        .buffer_occupancy (buffer_occupancy),
        .ahb_tx_commit    (ahb_tx_commit),
        .tx_packet        (tx_packet),
        .d_mode           (d_mode),
        .buffer_clear     (buffer_clear),
        .rx_data_avail    (rx_data_avail),
        .tx_complete      (tx_complete),
        .xact_error       (xact_error),
        .busy             (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one packet for exactly one posedge; returns on the following negedge.
    task automatic send(input rx_pid_t pid, input logic err);
        @(negedge clk);
        rx_packet       = pid;
        rx_packet_valid = 1'b1;
        rx_error        = err;
        @(negedge clk);
        rx_packet       = RX_NONE;
        rx_packet_valid = 1'b0;
        rx_error        = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin : stim
        int  cyc;
        bit  seen;
        bit  clr_seen;

        // Reset
        #1 n_rst = 1'b0;
        #4;
        check("rst_tx_packet", 32'(tx_packet), 32'(TX_NONE));
        check("rst_d_mode", 32'(d_mode), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", {28'd0, buffer_clear, rx_data_avail, tx_complete, xact_error}, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // T1: OUT + DATA0 accepted
        send(RX_OUT, 1'b0);
        check("t1_busy", 32'(busy), 1);
        check("t1_d_mode", 32'(d_mode), 1);
        check("t1_tx_idle", 32'(tx_packet), 32'(TX_NONE));
        send(RX_DATA0, 1'b0);
        check("t1_ack", 32'(tx_packet), 32'(TX_ACK));
        check("t1_no_clear", 32'(buffer_clear), 0);
        repeat (3) @(negedge clk);
        check("t1_ack_held", 32'(tx_packet), 32'(TX_ACK));
        check("t1_d_mode_held", 32'(d_mode), 1);
        done_pulse();
        check("t1_avail", 32'(rx_data_avail), 1);
        check("t1_tx_none", 32'(tx_packet), 32'(TX_NONE));
        check("t1_d_mode_off", 32'(d_mode), 0);
        check("t1_busy_off", 32'(busy), 0);
        @(negedge clk);
        check("t1_avail_pulse", 32'(rx_data_avail), 0);

        // T2: retransmitted DATA0 (toggle now 1)
        send(RX_OUT, 1'b0);
        send(RX_DATA0, 1'b0);
        check("t2_clear", 32'(buffer_clear), 1);
        check("t2_ack", 32'(tx_packet), 32'(TX_ACK));
        done_pulse();
        check("t2_no_avail", 32'(rx_data_avail), 0);
        // DATA1 is the expected toggle now
        send(RX_OUT, 1'b0);
        send(RX_DATA1, 1'b0);
        check("t2b_no_clear", 32'(buffer_clear), 0);
        done_pulse();
        check("t2b_avail", 32'(rx_data_avail), 1);

        // OUT while AHB still holds data -> NAK, buffer stays with AHB
        buffer_occupancy = 7'd5;
        send(RX_OUT, 1'b0);
        check("skip_busy", 32'(busy), 1);
        check("skip_d_mode", 32'(d_mode), 0);
        send(RX_DATA0, 1'b0);
        check("skip_nak", 32'(tx_packet), 32'(TX_NAK));
        check("skip_d_mode2", 32'(d_mode), 0);
        done_pulse();
        check("skip_idle", 32'(busy), 0);
        check("skip_no_avail", 32'(rx_data_avail), 0);
        buffer_occupancy = 7'd0;

        // RX error during OUT data phase aborts
        send(RX_OUT, 1'b0);
        send(RX_DATA0, 1'b1);
        check("err_xact", 32'(xact_error), 1);
        check("err_clear", 32'(buffer_clear), 1);
        check("err_busy", 32'(busy), 0);
        check("err_tx", 32'(tx_packet), 32'(TX_NONE));

        // Toggle 0 -> accept DATA0 (toggle 1), then SETUP resets it and DATA0 is new again
        send(RX_OUT, 1'b0);
        send(RX_DATA0, 1'b0);
        done_pulse();
        check("pre_setup_avail", 32'(rx_data_avail), 1);
        send(RX_SETUP, 1'b0);
        check("setup_d_mode", 32'(d_mode), 1);
        send(RX_DATA0, 1'b0);
        check("setup_no_clear", 32'(buffer_clear), 0);
        done_pulse();
        check("setup_avail", 32'(rx_data_avail), 1);

        // T4: IN with empty buffer -> NAK
        ahb_tx_commit = 1'b1;
        send(RX_IN, 1'b0);
        check("t4_nak", 32'(tx_packet), 32'(TX_NAK));
        check("t4_d_mode", 32'(d_mode), 0);
        done_pulse();
        check("t4_busy_off", 32'(busy), 0);

        // T5: IN with data, host never answers
        buffer_occupancy = 7'd8;
        send(RX_IN, 1'b0);
        check("t5_data0", 32'(tx_packet), 32'(TX_DATA0));
        check("t5_d_mode", 32'(d_mode), 1);
        done_pulse();
        check("t5_tx_none", 32'(tx_packet), 32'(TX_NONE));
        check("t5_wait_busy", 32'(busy), 1);
        cyc = 0;
        seen = 1'b0;
        clr_seen = 1'b0;
        for (int i = 1; i <= 600 && !seen; i++) begin
            @(negedge clk);
            if (buffer_clear) clr_seen = 1'b1;
            if (xact_error) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
        check("t5_timeout_cycles", 32'(cyc), TIMEOUT);
        check("t5_no_clear", 32'(clr_seen), 0);
        check("t5_idle", 32'(busy), 0);
        check("t5_d_mode_off", 32'(d_mode), 0);

        // T3: resend DATA0, host ACKs
        send(RX_IN, 1'b0);
        check("t3_resend_data0", 32'(tx_packet), 32'(TX_DATA0));
        done_pulse();
        send(RX_ACK, 1'b0);
        check("t3_clear", 32'(buffer_clear), 1);
        check("t3_complete", 32'(tx_complete), 1);
        check("t3_busy_off", 32'(busy), 0);
        // in_toggle flipped: next IN sends DATA1; host NAK keeps toggle
        send(RX_IN, 1'b0);
        check("t3_data1", 32'(tx_packet), 32'(TX_DATA1));
        done_pulse();
        send(RX_NAK, 1'b0);
        check("nak_xact", 32'(xact_error), 1);
        check("nak_no_clear", 32'(buffer_clear), 0);
        check("nak_no_complete", 32'(tx_complete), 0);

        // T6: async reset while in IN_SEND
        send(RX_IN, 1'b0);
        check("t6_data1_again", 32'(tx_packet), 32'(TX_DATA1));
        #2 n_rst = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx_packet), 32'(TX_NONE));
        check("t6_rst_d_mode", 32'(d_mode), 0);
        check("t6_rst_busy", 32'(busy), 0);
        @(negedge clk);
        n_rst = 1'b1;
        buffer_occupancy = 7'd0;
        send(RX_SETUP, 1'b0);
        send(RX_DATA0, 1'b0);
        check("t6_ack", 32'(tx_packet), 32'(TX_ACK));
        check("t6_no_clear", 32'(buffer_clear), 0);
        done_pulse();
        check("t6_avail", 32'(rx_data_avail), 1);
        buffer_occupancy = 7'd8;
        send(RX_IN, 1'b0);
        check("t6_in_data0", 32'(tx_packet), 32'(TX_DATA0));
        done_pulse();
        send(RX_ACK, 1'b0);
        check("t6_in_complete", 32'(tx_complete), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_protocol_ctrl.md
Name: usb_protocol_ctrl

Overview:
- Transaction-level sequencer between the USB RX controller, the USB TX encoder, the shared 64-byte data buffer and the AHB slave.
- Decodes received token/data/handshake PIDs and decides whether to ACK or NAK.
- Commands the TX encoder and tracks DATA0/DATA1 toggles.
- Grants shared-buffer ownership to either the AHB side or the USB side, and times out missing host responses.

Parameters:
- TIMEOUT_CYCLES, 512, clocks to wait for a host DATA/ACK before abandoning a transaction.
- BUF_DEPTH, 64, data buffer capacity in bytes; occupancy width is clog2(BUF_DEPTH)+1.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- rx_packet  in  3  decoded PID from RX, valid with rx_packet_valid (pkg rx_pid_t).
- rx_packet_valid  in  1  one-cycle pulse at packet EOP.
- rx_error  in  1  pulse: RX PID/EOP/CRC error for the current packet.
- tx_done  in  1  one-cycle pulse: TX finished sending the commanded packet.
- buffer_occupancy  in  7  bytes currently in the data buffer.
- ahb_tx_commit  in  1  level: AHB has loaded a complete IN payload.
- tx_packet  out  3  command to TX (pkg tx_pid_t); held non-NONE until tx_done.
- d_mode  out  1  buffer owner: 0 = AHB, 1 = USB.
- buffer_clear  out  1  one-cycle pulse: flush the data buffer.
- rx_data_avail  out  1  one-cycle pulse: accepted OUT payload is ready for AHB.
- tx_complete  out  1  one-cycle pulse: IN payload was ACKed by the host.
- xact_error  out  1  one-cycle pulse: timeout or RX error aborted a transaction.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state = IDLE, tx_packet = NONE, d_mode = 0.
  - All pulse outputs = 0, busy = 0.
  - out_toggle = 0, in_toggle = 0, timer = 0.
- Outputs are registered (Moore) and change one cycle after the causing input.
- Any rx_packet_valid arriving in a state that does not consume it is ignored.
- IDLE:
  - OUT token and occupancy == 0 -> OUT_DATA, d_mode = 1.
  - OUT token and occupancy != 0 (AHB has not drained the buffer) -> OUT_SKIP.
  - IN token and ahb_tx_commit and occupancy != 0 -> IN_SEND, d_mode = 1.
  - IN token otherwise -> SEND_NAK.
  - Any other PID -> stay in IDLE.
- OUT_DATA (timer runs):
  - DATA0/DATA1 with no rx_error and PID toggle == out_toggle -> SEND_ACK; toggle flips; rx_data_avail pulses on the ACK's tx_done.
  - DATA with toggle mismatch (retransmit) -> buffer_clear, then SEND_ACK; no flip, no rx_data_avail.
  - rx_error, timeout, or a non-DATA PID -> buffer_clear, xact_error, then IDLE.
- OUT_SKIP:
  - Next valid DATA packet -> SEND_NAK; payload is not written because d_mode stays 0.
  - Timeout -> IDLE.
- SEND_ACK / SEND_NAK: drive tx_packet = ACK / NAK until tx_done, then IDLE with d_mode = 0.
- IN_SEND: tx_packet = DATA0 or DATA1 per in_toggle; on tx_done -> IN_WAIT and the timer restarts.
- IN_WAIT:
  - ACK -> in_toggle flips, buffer_clear, tx_complete, then IDLE.
  - NAK, rx_error, timeout, or another token -> xact_error, then IDLE; buffer is kept and toggle is unchanged so the AHB payload can be resent.
- Timer:
  - Clears on every state entry and increments while in OUT_DATA, OUT_SKIP or IN_WAIT.
  - Timeout fires when timer == TIMEOUT_CYCLES-1; the timer saturates and does not wrap.
- Simultaneous rx_packet_valid and timeout on the same cycle: the packet wins.
- The SETUP PID resets both toggles to 0 and is then treated as OUT.
- d_mode returns to 0 on every transition into IDLE.
- Asynchronous reset mid-transaction returns every register to its reset value immediately; the TX encoder sees tx_packet = NONE.

Decomposition:
- Package usb_pkg holds:
  - rx_pid_t: NONE, OUT, IN, DATA0, DATA1, ACK, NAK, SETUP.
  - tx_pid_t: NONE, DATA0, DATA1, ACK, NAK, STALL.
  - ctrl_state_t.
  - The BUF_DEPTH default.
- One sub-module: xact_timer (loadable saturating counter with clear, enable and timeout outputs), reusable by the RX path.

Test Plan:
1. OUT, then DATA0 (out_toggle = 0, occupancy 0) -> d_mode = 1, tx_packet = ACK until tx_done; rx_data_avail pulses; out_toggle = 1; d_mode = 0.
2. Repeat DATA0 after the previous ACK -> buffer_clear pulses, ACK is sent, no rx_data_avail, out_toggle stays 1.
3. IN with ahb_tx_commit = 1 and occupancy 8 -> tx_packet = DATA0; after tx_done the host sends ACK -> buffer_clear and tx_complete pulse, in_toggle = 1.
4. IN with occupancy 0 -> tx_packet = NAK, no toggle change, busy falls after tx_done.
5. IN, DATA sent, no host response -> xact_error exactly TIMEOUT_CYCLES cycles after tx_done; buffer is not cleared; the next IN resends DATA0.
6. Assert n_rst low during IN_SEND -> tx_packet = NONE and d_mode = 0 asynchronously; SETUP then OUT/DATA0 is accepted with toggle 0.
